dotproduct_sequencer: RTL and testbench
=======================================

// Module: dotproduct_sequencer
// PURPOSE
//  Sequences a length-(K*N) signed dot product through one N-wide DotProduct datapath.
//  Accepts K chunks of N operand pairs over a valid/ready stream and accumulates each
//  chunk's partial sum into an ACC_WIDTH register. Presents the final sum on a
//  valid/ready result port. Sits between the NPU operand fetch logic and the
//  writeback logic.
// PARAMETERS
//  N           4                        lanes per chunk; passed to the DotProduct instance
//  MAX_CHUNKS  16                       largest K accepted per job
//  CW          $clog2(MAX_CHUNKS+1)     width of the chunk counter (derived; do not override)
// PORTS
//  clk          in   1                  single clock, rising edge
//  rst_n        in   1                  asynchronous, active-low reset
//  start_i      in   1                  job start; sampled only in IDLE
//  num_chunks_i in   CW                 K for the job; sampled with start_i
//  abort_i      in   1                  synchronous job cancel
//  busy_o       out  1                  high whenever state != IDLE
//  in_valid_i   in   1                  chunk valid
//  in_ready_o   out  1                  chunk ready
//  x_i          in   DATA_WIDTH x N     signed activation chunk
//  w_i          in   DATA_WIDTH x N     signed weight chunk
//  out_valid_o  out  1                  result valid
//  out_ready_i  in   1                  result ready
//  out_data_o   out  ACC_WIDTH          signed final sum
//  out_sat_o    out  1                  sticky saturation flag (see CONFIGURATION)
// BEHAVIOUR
//  - States: IDLE, ACCUM, DONE.
//  - Reset (async, any state): state=IDLE; acc=0; remaining=0; sat=0.
//    All outputs read 0: busy_o, in_ready_o, out_valid_o, out_data_o, out_sat_o.
//  - IDLE:
//    - start_i and num_chunks_i!=0: remaining<=num_chunks_i, acc<=0, sat<=0 -> ACCUM.
//    - start_i and num_chunks_i==0: acc<=0, sat<=0 -> DONE (empty job, result 0).
//    - num_chunks_i>MAX_CHUNKS: clamped to MAX_CHUNKS.
//    - start_i in any other state is ignored.
//  - ACCUM:
//    - in_ready_o = 1, driven combinationally from state.
//    - Handshake (in_valid_i & in_ready_o): acc <= acc + DotProduct(x_i, w_i);
//      remaining <= remaining-1. The DotProduct datapath is combinational.
//    - Handshake with remaining==1 -> DONE.
//    - in_valid_i low: the state holds, with no bubble penalty.
//  - DONE:
//    - out_valid_o=1; out_data_o=acc; out_sat_o=sat. All are stable until the handshake.
//    - out_ready_i -> IDLE next cycle. out_data_o keeps its value in IDLE (only
//      out_valid_o drops).
//  - Latency: out_valid_o rises the cycle after the last chunk handshake.
//    Throughput: 1 chunk/cycle.
//    Minimum job period: K+2 cycles (start, K chunks, result handshake).
//  - abort_i has priority over everything in every state:
//    next state IDLE, acc<=0, sat<=0, and no handshake is accepted that cycle.
//    in_ready_o and out_valid_o are also forced to 0 in the abort cycle.
//  - Arithmetic: two's-complement signed throughout.
//    - The partial sum is sign-extended to ACC_WIDTH before the add.
//    - With no macro, the sum wraps modulo 2^ACC_WIDTH.
// CONFIGURATION
//  DOTPRODUCT_SEQ_SAT_EN defined:
//    - The accumulate saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//      Overflow is detected on a one-bit-wider sum.
//    - Any clamp sets sat, which is sticky until the next start or abort.
//  DOTPRODUCT_SEQ_SAT_EN undefined:
//    - Wrapping add; out_sat_o is tied to 0.
//    - The port is always present.
// STRUCTURE
//  - Shared package kiwi_npu_pkg:
//    - dpseq_state_t enum {IDLE, ACCUM, DONE}.
//    - Signed typedefs data_t [DATA_WIDTH] and acc_t [ACC_WIDTH], taken from the
//      width.svh macros.
//    - Saturation-limit constants ACC_MAX and ACC_MIN.
//  - One sub-module: the existing DotProduct #(.N(N)), instantiated once and fed
//    directly by x_i/w_i.
//  - The FSM, counter and accumulator live in this file.
// TESTING
//  - Single chunk:
//    start K=1; x={1,2,3,4}, w={5,6,7,8}.
//    -> out_valid_o the next cycle; out_data_o=70.
//  - Two chunks:
//    chunk 1 as above, then x={-1,-1,-1,-1}, w={2,2,2,2}, with a 2-cycle
//    in_valid_i gap in between.
//    -> out_data_o=62; out_valid_o 1 cycle after the second handshake.
//  - Backpressure:
//    hold out_ready_i=0 for 5 cycles in DONE.
//    -> out_data_o stable, in_ready_o=0, start_i ignored; IDLE the cycle after ready.
//  - Empty job and abort:
//    - K=0 -> DONE with out_data_o=0.
//    - A separate K=4 job aborted after 2 chunks -> IDLE, no out_valid_o.
//      The next K=1 job returns the clean 70.
//  - Overflow:
//    max-positive x,w, K=MAX_CHUNKS, with the ACC_WIDTH override narrowed so the
//    accumulation exceeds ACC_MAX.
//    -> with SAT_EN: ACC_MAX and out_sat_o=1.
//    -> without: the wrapped value and out_sat_o=0.
//  - Async reset:
//    rst_n low mid-ACCUM, between clock edges.
//    -> all outputs 0 immediately; after release the first K=1 job returns 70.

Source files
------------

// File: rtl/kiwi_npu_pkg.sv
// Shared NPU types: operand/accumulator widths, sequencer state encoding, saturation limits.
// Widths come from KIWI_DATA_WIDTH / KIWI_ACC_WIDTH when defined on the command line.
`ifndef KIWI_DATA_WIDTH
`define KIWI_DATA_WIDTH 8
`endif
`ifndef KIWI_ACC_WIDTH
`define KIWI_ACC_WIDTH 20
`endif

package kiwi_npu_pkg;

    localparam int DATA_WIDTH = `KIWI_DATA_WIDTH;
    localparam int ACC_WIDTH  = `KIWI_ACC_WIDTH;

    typedef logic signed [DATA_WIDTH-1:0] data_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } dpseq_state_t;

    localparam acc_t ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam acc_t ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

endpackage

// File: rtl/dotproduct_sequencer_if.sv
// Job control, chunk stream and result stream of the dot-product sequencer.
// master = operand fetch / writeback side, slave = sequencer.
interface dotproduct_sequencer_if
    import kiwi_npu_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 5
);
    logic              start_i;
    logic [CW-1:0]     num_chunks_i;
    logic              abort_i;
    logic              busy_o;
    logic              in_valid_i;
    logic              in_ready_o;
    data_t [N-1:0]     x_i;
    data_t [N-1:0]     w_i;
    logic              out_valid_o;
    logic              out_ready_i;
    acc_t              out_data_o;
    logic              out_sat_o;

    modport master (
        output start_i, num_chunks_i, abort_i, in_valid_i, x_i, w_i, out_ready_i,
        input  busy_o, in_ready_o, out_valid_o, out_data_o, out_sat_o
    );

    modport slave (
        input  start_i, num_chunks_i, abort_i, in_valid_i, x_i, w_i, out_ready_i,
        output busy_o, in_ready_o, out_valid_o, out_data_o, out_sat_o
    );
endinterface

// File: rtl/dotproduct_sequencer_dot.sv
// DotProduct: combinational N-lane signed multiply-add tree.
// Result width grows by clog2(N) bits so the lane sum can never overflow.
module DotProduct
    import kiwi_npu_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = 2*DATA_WIDTH + $clog2(N)
) (
    input  data_t [N-1:0]        x,
    input  data_t [N-1:0]        w,
    output logic signed [PW-1:0] dot
);
    localparam int MW = 2*DATA_WIDTH;

    always_comb begin
        logic signed [MW-1:0] prod;
        dot = '0;
        for (int k = 0; k < N; k++) begin
            prod = $signed(x[k]) * $signed(w[k]);
            dot  = dot + $signed({{(PW-MW){prod[MW-1]}}, prod});
        end
    end
endmodule

// File: rtl/dotproduct_sequencer.sv
// Sequences a K-chunk signed dot product through one DotProduct instance into an accumulator.
// Define DOTPRODUCT_SEQ_SAT_EN for a saturating accumulate with sticky flag; default wraps.
module dotproduct_sequencer
    import kiwi_npu_pkg::*;
#(
    parameter int N          = 4,
    parameter int MAX_CHUNKS = 16,
    parameter int CW         = $clog2(MAX_CHUNKS+1)
) (
    input logic                     clk,
    input logic                     rst_n,
    dotproduct_sequencer_if.slave   bus
);
    localparam int PW = 2*DATA_WIDTH + $clog2(N);

    dpseq_state_t              state, state_nxt;
    acc_t                      acc, acc_nxt;
    logic [CW-1:0]             remaining, rem_nxt;
    logic                      sat, sat_nxt;
    logic [CW-1:0]             num_clamped;
    logic signed [PW-1:0]      psum;
    acc_t                      psum_ext;
    logic signed [ACC_WIDTH:0] sum_wide;
    logic                      in_hs;

    function automatic logic acc_ovf(input logic signed [ACC_WIDTH:0] s);
        return s[ACC_WIDTH] != s[ACC_WIDTH-1];
    endfunction

    function automatic acc_t acc_sat(input logic signed [ACC_WIDTH:0] s);
        if (acc_ovf(s))
            return s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        return s[ACC_WIDTH-1:0];
    endfunction

    function automatic acc_t acc_wrap(input logic signed [ACC_WIDTH:0] s);
        return s[ACC_WIDTH-1:0];
    endfunction

    DotProduct #(.N(N)) u_dot (
        .x   (bus.x_i),
        .w   (bus.w_i),
        .dot (psum)
    );

    // One bit of headroom so overflow is visible before saturation or wrap.
    assign psum_ext = $signed({{(ACC_WIDTH-PW){psum[PW-1]}}, psum});
    assign sum_wide = $signed({acc[ACC_WIDTH-1], acc}) + $signed({psum_ext[ACC_WIDTH-1], psum_ext});

    assign num_clamped = (bus.num_chunks_i > CW'(MAX_CHUNKS)) ? CW'(MAX_CHUNKS) : bus.num_chunks_i;

    assign bus.busy_o      = (state != IDLE);
    assign bus.in_ready_o  = (state == ACCUM) && !bus.abort_i;
    assign bus.out_valid_o = (state == DONE) && !bus.abort_i;
    assign bus.out_data_o  = acc;
    // Without saturation sat is never set, so the flag reads constant 0.
    assign bus.out_sat_o   = sat;
    assign in_hs           = bus.in_valid_i && bus.in_ready_o;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        rem_nxt   = remaining;
        sat_nxt   = sat;
        if (bus.abort_i) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            sat_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        acc_nxt = '0;
                        sat_nxt = 1'b0;
                        if (num_clamped == '0) begin
                            state_nxt = DONE;
                        end else begin
                            rem_nxt   = num_clamped;
                            state_nxt = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_hs) begin
`ifdef DOTPRODUCT_SEQ_SAT_EN
                        acc_nxt = acc_sat(sum_wide);
                        sat_nxt = sat | acc_ovf(sum_wide);
`else
                        acc_nxt = acc_wrap(sum_wide);
`endif
                        rem_nxt = remaining - 1'b1;
                        if (remaining == CW'(1))
                            state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready_i)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            sat       <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            remaining <= rem_nxt;
            sat       <= sat_nxt;
        end
    end
endmodule

// File: tb/tb_dotproduct_sequencer.sv
// Directed bench for dotproduct_sequencer: chunk accumulate, gaps, backpressure, empty job,
// abort, clamped K with overflow, and asynchronous reset.
module tb_dotproduct_sequencer;
    import kiwi_npu_pkg::*;

    localparam int N  = 4;
    localparam int CW = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dotproduct_sequencer_if #(.N(N), .CW(CW)) bus ();

    dotproduct_sequencer #(.N(N), .MAX_CHUNKS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_chunk_a();
        bus.x_i = {8'sd4, 8'sd3, 8'sd2, 8'sd1};
        bus.w_i = {8'sd8, 8'sd7, 8'sd6, 8'sd5};
    endtask

    task automatic run_k1(input string tag);
        bus.start_i      = 1'b1;
        bus.num_chunks_i = 5'd1;
        step();
        bus.start_i    = 1'b0;
        set_chunk_a();
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        chk({tag, "_valid"}, int'(bus.out_valid_o), 1);
        chk({tag, "_data"}, int'(bus.out_data_o), 70);
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;
        chk({tag, "_idle"}, int'(bus.busy_o), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n            = 1'b0;
        bus.start_i      = 1'b0;
        bus.num_chunks_i = '0;
        bus.abort_i      = 1'b0;
        bus.in_valid_i   = 1'b0;
        bus.x_i          = '0;
        bus.w_i          = '0;
        bus.out_ready_i  = 1'b0;
        step();
        step();
        chk("rst_busy", int'(bus.busy_o), 0);
        chk("rst_in_ready", int'(bus.in_ready_o), 0);
        chk("rst_out_valid", int'(bus.out_valid_o), 0);
        chk("rst_out_data", int'(bus.out_data_o), 0);
        chk("rst_out_sat", int'(bus.out_sat_o), 0);
        rst_n = 1'b1;
        step();

        // single chunk
        bus.start_i      = 1'b1;
        bus.num_chunks_i = 5'd1;
        step();
        bus.start_i = 1'b0;
        chk("k1_busy", int'(bus.busy_o), 1);
        chk("k1_in_ready", int'(bus.in_ready_o), 1);
        set_chunk_a();
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        chk("k1_out_valid", int'(bus.out_valid_o), 1);
        chk("k1_out_data", int'(bus.out_data_o), 70);
        chk("k1_in_ready_done", int'(bus.in_ready_o), 0);
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;
        chk("k1_idle_valid", int'(bus.out_valid_o), 0);
        chk("k1_idle_busy", int'(bus.busy_o), 0);
        chk("k1_idle_data_kept", int'(bus.out_data_o), 70);

        // two chunks with a 2-cycle gap
        bus.start_i      = 1'b1;
        bus.num_chunks_i = 5'd2;
        step();
        bus.start_i = 1'b0;
        set_chunk_a();
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        step();
        step();
        chk("k2_gap_in_ready", int'(bus.in_ready_o), 1);
        chk("k2_gap_out_valid", int'(bus.out_valid_o), 0);
        bus.x_i = {-8'sd1, -8'sd1, -8'sd1, -8'sd1};
        bus.w_i = {8'sd2, 8'sd2, 8'sd2, 8'sd2};
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        chk("k2_out_valid", int'(bus.out_valid_o), 1);
        chk("k2_out_data", int'(bus.out_data_o), 62);

        // backpressure in DONE, start ignored
        bus.start_i      = 1'b1;
        bus.num_chunks_i = 5'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", int'(bus.out_valid_o), 1);
            chk("bp_out_data", int'(bus.out_data_o), 62);
            chk("bp_in_ready", int'(bus.in_ready_o), 0);
        end
        bus.start_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;
        chk("bp_idle_busy", int'(bus.busy_o), 0);

        // empty job
        bus.start_i      = 1'b1;
        bus.num_chunks_i = 5'd0;
        step();
        bus.start_i = 1'b0;
        chk("k0_out_valid", int'(bus.out_valid_o), 1);
        chk("k0_out_data", int'(bus.out_data_o), 0);
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;
        chk("k0_idle_busy", int'(bus.busy_o), 0);

        // K=4 aborted after 2 chunks
        bus.start_i      = 1'b1;
        bus.num_chunks_i = 5'd4;
        step();
        bus.start_i = 1'b0;
        set_chunk_a();
        bus.in_valid_i = 1'b1;
        step();
        step();
        chk("ab_partial", int'(bus.out_data_o), 140);
        bus.abort_i = 1'b1;
        #1;
        chk("ab_in_ready_forced", int'(bus.in_ready_o), 0);
        step();
        bus.abort_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("ab_busy", int'(bus.busy_o), 0);
        chk("ab_out_valid", int'(bus.out_valid_o), 0);
        chk("ab_out_data", int'(bus.out_data_o), 0);
        run_k1("ab_next");

        // overflow with K requested as 20, clamped to 16
        bus.start_i      = 1'b1;
        bus.num_chunks_i = 5'd20;
        step();
        bus.start_i = 1'b0;
        bus.x_i = {8'sd127, 8'sd127, 8'sd127, 8'sd127};
        bus.w_i = {8'sd127, 8'sd127, 8'sd127, 8'sd127};
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("ov_not_done_15", int'(bus.out_valid_o), 0);
        step();
        bus.in_valid_i = 1'b0;
        chk("ov_done_16", int'(bus.out_valid_o), 1);
`ifdef DOTPRODUCT_SEQ_SAT_EN
        chk("ov_data", int'(bus.out_data_o), 524287);
        chk("ov_sat", int'(bus.out_sat_o), 1);
`else
        chk("ov_data", int'(bus.out_data_o), -16320);
        chk("ov_sat", int'(bus.out_sat_o), 0);
`endif
        bus.out_ready_i = 1'b1;
        step();
        bus.out_ready_i = 1'b0;

        // async reset mid-ACCUM
        bus.start_i      = 1'b1;
        bus.num_chunks_i = 5'd2;
        step();
        bus.start_i = 1'b0;
        set_chunk_a();
        bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_busy", int'(bus.busy_o), 0);
        chk("ar_in_ready", int'(bus.in_ready_o), 0);
        chk("ar_out_valid", int'(bus.out_valid_o), 0);
        chk("ar_out_data", int'(bus.out_data_o), 0);
        chk("ar_out_sat", int'(bus.out_sat_o), 0);
        #3;
        rst_n = 1'b1;
        step();
        run_k1("ar_next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
